// File: rtl/my_rx_fifo_pkg.sv
// Shared UART FIFO definitions, used by both the RX and TX buffers.
package my_rx_fifo_pkg;

    localparam int UART_BYTE_W = 8;

    // Pointer carries one extra wrap bit above the index so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/my_fifo_ram.sv
// DEPTH x DW storage array: synchronous write, combinational read (LUTRAM or flops).
module my_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // No reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/my_rx_fifo.sv
// RX byte buffer behind the deserializer: FWFT valid/ready output,
// sticky overrun flag and saturating framing-error counter.
module my_rx_fifo
    import my_rx_fifo_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [UART_BYTE_W-1:0]   in_data,
    input  logic                     in_error,
    output logic                     out_valid,
    output logic [UART_BYTE_W-1:0]   out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun,
    output logic [ERR_CNT_WIDTH-1:0] frame_err_cnt,
    input  logic                     clear_flags
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic                     r_overrun;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_good;
    logic                     w_push;
    logic                     w_drop;
    logic [UART_BYTE_W-1:0]   w_rdata;
    logic [ERR_CNT_WIDTH-1:0] w_err_base;
    logic [ERR_CNT_WIDTH-1:0] w_err_next;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // An error pulse always wins over a coincident data pulse.
    assign w_pop  = !w_empty && out_ready;
    assign w_good = in_valid && !in_error;
    assign w_push = w_good && (!w_full || w_pop);
    assign w_drop = w_good && w_full && !w_pop;

    // Clear applies first, so a coincident event still lands in the flags.
    always_comb begin
        w_err_base = clear_flags ? '0 : r_err_cnt;
        w_err_next = w_err_base;
        if (in_error && (w_err_base != ERR_MAX)) w_err_next = w_err_base + ERR_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_overrun <= (clear_flags ? 1'b0 : r_overrun) | w_drop;
            r_err_cnt <= w_err_next;
        end
    end

    my_fifo_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (UART_BYTE_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

    // Gate stale RAM contents so the output reads zero whenever nothing is held.
    assign out_data      = w_empty ? '0 : w_rdata;
    assign out_valid     = !w_empty;
    assign empty         = w_empty;
    assign full          = w_full;
    assign count         = r_wr_ptr - r_rd_ptr;
    assign overrun       = r_overrun;
    assign frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_my_rx_fifo.sv
// Bench for my_rx_fifo: queue-based reference model checked every cycle, plus directed literal checks.
module tb_my_rx_fifo;

    localparam int DEPTH = 16;
    localparam int EW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int EMAX  = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_error = 1'b0;
    logic          out_ready = 1'b0;
    logic          clear_flags = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overrun;
    logic [EW-1:0] frame_err_cnt;

    int total = 0;
    int bad = 0;

    logic [7:0] mq[$];
    bit         m_ov = 1'b0;
    int         m_ec = 0;
    bit         chk_en = 1'b0;
    logic [7:0] got[$];

    my_rx_fifo #(.DEPTH(DEPTH), .ERR_CNT_WIDTH(EW)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_error      (in_error),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .overrun       (overrun),
        .frame_err_cnt (frame_err_cnt),
        .clear_flags   (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus flags, updated from the rules on each edge.
    initial begin
        bit pop, good, drop;
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                mq.delete();
                m_ov = 1'b0;
                m_ec = 0;
            end else begin
                pop  = (mq.size() > 0) && out_ready;
                good = in_valid && !in_error;
                drop = good && (mq.size() == DEPTH) && !pop;
                if (pop) void'(mq.pop_front());
                if (good && !drop) mq.push_back(in_data);
                if (clear_flags) begin
                    m_ov = 1'b0;
                    m_ec = 0;
                end
                if (drop) m_ov = 1'b1;
                if (in_error && m_ec < EMAX) m_ec++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_valid", out_valid, mq.size() != 0);
                chk("m_count", count, mq.size());
                chk("m_full", full, mq.size() == DEPTH);
                chk("m_empty", empty, mq.size() == 0);
                chk("m_overrun", overrun, m_ov);
                chk("m_errcnt", frame_err_cnt, m_ec);
                if (mq.size() != 0) chk("m_data", out_data, mq[0]);
            end
        end
    end

    // Inputs are set just after a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit e, input bit r, input bit c);
        in_valid = v; in_data = d; in_error = e; out_ready = r; clear_flags = c;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain_collect(input int n);
        got.delete();
        for (int i = 0; i < n; i++) begin
            got.push_back(out_data);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_errcnt", frame_err_cnt, 0);
        resetn = 1'b1;
        chk_en = 1'b1;
        idle();

        // single byte latency
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 8'hA5);
        chk("lat_count", count, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("lat_empty", empty, 1);
        chk("lat_count0", count, 0);
        idle();

        // fill, overrun, ordered drain
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_count", count, 16);
        drain_collect(16);
        for (int i = 0; i < 16; i++) chk("drain_order", got[i], i);
        chk("drain_empty", empty, 1);
        chk("drain_ovr_sticky", overrun, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_overrun", overrun, 0);

        // simultaneous push and pop at full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        chk("pp_count", count, 16);
        chk("pp_overrun", overrun, 0);
        chk("pp_head", out_data, 8'h11);
        idle();
        drain_collect(16);
        for (int i = 0; i < 15; i++) chk("pp_order", got[i], 8'h11 + i);
        chk("pp_last", got[15], 8'h77);

        // framing errors
        step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        chk("err_one", frame_err_cnt, 1);
        chk("err_nopush", count, 0);
        chk("err_noovr", overrun, 0);
        for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("err_sat", frame_err_cnt, 255);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("err_clr_coinc", frame_err_cnt, 1);
        idle();

        // clear coinciding with a drop keeps overrun set
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        chk("clr_drop_ovr", overrun, 1);
        chk("clr_drop_err", frame_err_cnt, 0);
        chk("clr_drop_count", count, 16);

        // random interleaved traffic across many wraps
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        idle();

        // async reset with count=5
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        idle();
        chk("pre_rst_count", count, 5);
        chk("pre_rst_ovr", overrun, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_valid", out_valid, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_count", count, 0);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", out_data, 8'hC3);
        chk("post_rst_count", count, 1);
        idle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
